// File: rtl/onchip_arb_pkg.sv
// Shared types and default parameter values for the two-master on-chip
// memory arbiter.
//   owner_e       : which master currently holds the lock
//   DEF_*         : default values for the arbiter parameters
package onchip_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_e;

    localparam int DEF_ADDR_W       = 13;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_NUM_WORDS    = 5120;
    localparam int DEF_LOCK_TIMEOUT = 16;

endpackage

// File: rtl/onchip_arb_lock_timer.sv
// Idle-cycle counter for the lock owner.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : return the count to zero (owner granted, or no owner)
//   count      : owner held the lock but did not request this cycle
//   expire     : this is the LOCK_TIMEOUT-th consecutive idle cycle
module onchip_arb_lock_timer
    import onchip_arb_pkg::*;
#(
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expire
);

    localparam int              CNT_W = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(LOCK_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The count holds the number of idle cycles already seen, so the cycle
    // that would bring it to LOCK_TIMEOUT is the one that expires.
    assign expire = count & (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || expire) begin
            cnt_d = '0;
        end else if (count) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Two-master arbiter in front of an external single-port synchronous RAM.
// Round-robin on ties, optional lock with idle timeout, one-cycle read
// latency, out-of-range accesses answered locally with zero data.
//   clk, reset                  : clock, asynchronous active-high reset
//   a_* / b_*                   : master ports (read/write/lock requests,
//                                 waitrequest, shared readdata, per-master
//                                 readdatavalid)
//   mem_*                       : RAM-side controls; mem_readdata is valid
//                                 one cycle after the address
//   range_err, lock_timeout_err,
//   proto_err                   : sticky error flags, cleared by reset
//
// Lock owner states:
//   state    | meaning
//   OWN_NONE | no lock, round-robin arbitration between requesters
//   OWN_A    | master A holds the grant, B waits
//   OWN_B    | master B holds the grant, A waits
module onchip_mem_arbiter
    import onchip_arb_pkg::*;
#(
    parameter int  ADDR_W       = DEF_ADDR_W,
    parameter int  DATA_W       = DEF_DATA_W,
    parameter int  NUM_WORDS    = DEF_NUM_WORDS,
    parameter int  LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    localparam int BE_W         = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] a_address,
    input  logic [BE_W-1:0]   a_byteenable,
    input  logic              a_read,
    input  logic              a_write,
    input  logic [DATA_W-1:0] a_writedata,
    input  logic              a_lock,
    output logic              a_waitrequest,
    output logic [DATA_W-1:0] a_readdata,
    output logic              a_readdatavalid,

    input  logic [ADDR_W-1:0] b_address,
    input  logic [BE_W-1:0]   b_byteenable,
    input  logic              b_read,
    input  logic              b_write,
    input  logic [DATA_W-1:0] b_writedata,
    input  logic              b_lock,
    output logic              b_waitrequest,
    output logic [DATA_W-1:0] b_readdata,
    output logic              b_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,

    output logic              range_err,
    output logic              lock_timeout_err,
    output logic              proto_err
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_WORDS);

    owner_e owner_q, owner_d;
    logic   last_b_q, last_b_d;
    logic   rd_pend_q, rd_pend_d;
    logic   rd_to_b_q, rd_to_b_d;
    logic   rd_zero_q, rd_zero_d;
    logic   range_err_q, range_err_d;
    logic   tmo_err_q, tmo_err_d;
    logic   proto_err_q, proto_err_d;

    logic              req_a, req_b;
    logic              grant_a, grant_b, grant;
    logic [ADDR_W-1:0] sel_address;
    logic              sel_read, sel_write, sel_lock;
    logic              in_range;
    logic              owner_req, owner_grant;
    logic              tmr_clear, tmr_count, tmr_expire;

    assign req_a = a_read | a_write;
    assign req_b = b_read | b_write;

    // Grants are gated by reset so nothing is accepted while it is held.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset) begin
            case (owner_q)
                OWN_A:   grant_a = req_a;
                OWN_B:   grant_b = req_b;
                default: begin
                    if (req_a && req_b) begin
                        grant_a = last_b_q;
                        grant_b = ~last_b_q;
                    end else begin
                        grant_a = req_a;
                        grant_b = req_b;
                    end
                end
            endcase
        end
    end

    assign grant         = grant_a | grant_b;
    assign a_waitrequest = req_a & ~grant_a;
    assign b_waitrequest = req_b & ~grant_b;

    assign sel_address    = grant_b ? b_address    : a_address;
    assign sel_read       = grant_b ? b_read       : a_read;
    assign sel_write      = grant_b ? b_write      : a_write;
    assign sel_lock       = grant_b ? b_lock       : a_lock;
    assign mem_address    = sel_address;
    assign mem_byteenable = grant_b ? b_byteenable : a_byteenable;
    assign mem_writedata  = grant_b ? b_writedata  : a_writedata;

    assign in_range       = {1'b0, sel_address} < LIMIT;
    assign mem_chipselect = grant & in_range;
    // A combined read+write is executed as a write.
    assign mem_write      = mem_chipselect & sel_write;
    assign mem_clken      = 1'b1;

    // Out-of-range reads still produce a valid beat, carrying zero.
    assign a_readdatavalid = rd_pend_q & ~rd_to_b_q;
    assign b_readdatavalid = rd_pend_q & rd_to_b_q;
    assign a_readdata      = rd_zero_q ? '0 : mem_readdata;
    assign b_readdata      = a_readdata;

    assign range_err        = range_err_q;
    assign lock_timeout_err = tmo_err_q;
    assign proto_err        = proto_err_q;

    assign owner_req   = ((owner_q == OWN_A) & req_a)   | ((owner_q == OWN_B) & req_b);
    assign owner_grant = ((owner_q == OWN_A) & grant_a) | ((owner_q == OWN_B) & grant_b);
    assign tmr_clear   = (owner_q == OWN_NONE) | owner_grant;
    assign tmr_count   = (owner_q != OWN_NONE) & ~owner_req;

    onchip_arb_lock_timer #(
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) u_lock_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .count  (tmr_count),
        .expire (tmr_expire)
    );

    always_comb begin
        owner_d = owner_q;
        case (owner_q)
            OWN_NONE: begin
                if (grant && sel_lock) begin
                    owner_d = grant_b ? OWN_B : OWN_A;
                end
            end
            OWN_A: begin
                if (tmr_expire || (grant_a && !a_lock)) begin
                    owner_d = OWN_NONE;
                end
            end
            OWN_B: begin
                if (tmr_expire || (grant_b && !b_lock)) begin
                    owner_d = OWN_NONE;
                end
            end
            default: owner_d = OWN_NONE;
        endcase
    end

    always_comb begin
        last_b_d    = grant ? grant_b : last_b_q;
        rd_pend_d   = grant & sel_read & ~sel_write;
        rd_to_b_d   = grant_b;
        rd_zero_d   = ~in_range;
        range_err_d = range_err_q | (grant & ~in_range);
        tmo_err_d   = tmo_err_q | tmr_expire;
        proto_err_d = proto_err_q | (grant & sel_read & sel_write);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q     <= OWN_NONE;
            last_b_q    <= 1'b1;
            rd_pend_q   <= 1'b0;
            rd_to_b_q   <= 1'b0;
            rd_zero_q   <= 1'b0;
            range_err_q <= 1'b0;
            tmo_err_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            last_b_q    <= last_b_d;
            rd_pend_q   <= rd_pend_d;
            rd_to_b_q   <= rd_to_b_d;
            rd_zero_q   <= rd_zero_d;
            range_err_q <= range_err_d;
            tmo_err_q   <= tmo_err_d;
            proto_err_q <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_onchip_mem_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int NW = 5120;
    localparam int LT = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] a_address, b_address;
    logic [3:0]    a_byteenable, b_byteenable;
    logic          a_read, a_write, a_lock, b_read, b_write, b_lock;
    logic [DW-1:0] a_writedata, b_writedata;
    logic          a_waitrequest, b_waitrequest;
    logic [DW-1:0] a_readdata, b_readdata;
    logic          a_readdatavalid, b_readdatavalid;
    logic [AW-1:0] mem_address;
    logic [3:0]    mem_byteenable;
    logic [DW-1:0] mem_writedata;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [DW-1:0] mem_readdata = '0;
    logic          range_err, lock_timeout_err, proto_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    onchip_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_WORDS(NW), .LOCK_TIMEOUT(LT)
    ) dut (
        .clk(clk), .reset(reset),
        .a_address(a_address), .a_byteenable(a_byteenable), .a_read(a_read),
        .a_write(a_write), .a_writedata(a_writedata), .a_lock(a_lock),
        .a_waitrequest(a_waitrequest), .a_readdata(a_readdata),
        .a_readdatavalid(a_readdatavalid),
        .b_address(b_address), .b_byteenable(b_byteenable), .b_read(b_read),
        .b_write(b_write), .b_writedata(b_writedata), .b_lock(b_lock),
        .b_waitrequest(b_waitrequest), .b_readdata(b_readdata),
        .b_readdatavalid(b_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .range_err(range_err), .lock_timeout_err(lock_timeout_err), .proto_err(proto_err)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE0000 | 32'(i);
    endfunction

    // Synchronous single-port RAM, preloaded on the first clock edge.
    logic [31:0] ram [0:NW-1];
    logic        ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < NW; i++) ram[i] <= init_word(i);
            ram_init <= 1'b1;
        end else if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model and per-cycle compare.
    logic [31:0] ref_mem [0:NW-1];
    initial begin : compare
        int          owner;          // 0 none, 1 A, 2 B
        int          idle;
        bit          last_b, pend, pend_b, m_rng, m_tmo, m_proto;
        logic [31:0] pend_data;
        bit          ra, rb, ga, gb, g, s_rd, s_wr, s_lk, inr, own_req, own_g;
        logic [AW-1:0] s_addr;
        logic [31:0] s_wd;
        logic [3:0]  s_be;
        for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
        owner = 0; idle = 0; last_b = 1; pend = 0; pend_b = 0; pend_data = '0;
        m_rng = 0; m_tmo = 0; m_proto = 0;
        forever begin
            @(negedge clk);
            ra = a_read | a_write;
            rb = b_read | b_write;
            if (reset) begin
                chk("rst_a_wait", a_waitrequest, ra);
                chk("rst_b_wait", b_waitrequest, rb);
                chk("rst_cs", mem_chipselect, 0);
                chk("rst_rdv", {a_readdatavalid, b_readdatavalid}, 0);
                chk("rst_flags", {range_err, lock_timeout_err, proto_err}, 0);
                owner = 0; idle = 0; last_b = 1; pend = 0;
                m_rng = 0; m_tmo = 0; m_proto = 0;
            end else begin
                ga = 0; gb = 0;
                if (owner == 1)      ga = ra;
                else if (owner == 2) gb = rb;
                else if (ra && rb) begin ga = last_b; gb = !last_b; end
                else begin ga = ra; gb = rb; end
                g      = ga | gb;
                s_addr = gb ? b_address : a_address;
                s_rd   = gb ? b_read : a_read;
                s_wr   = gb ? b_write : a_write;
                s_lk   = gb ? b_lock : a_lock;
                s_wd   = gb ? b_writedata : a_writedata;
                s_be   = gb ? b_byteenable : a_byteenable;
                inr    = (int'(s_addr) < NW);

                chk("a_wait", a_waitrequest, ra && !ga);
                chk("b_wait", b_waitrequest, rb && !gb);
                chk("a_rdv", a_readdatavalid, pend && !pend_b);
                chk("b_rdv", b_readdatavalid, pend && pend_b);
                if (pend) begin
                    chk("rdata_a", a_readdata, pend_data);
                    chk("rdata_b", b_readdata, pend_data);
                end
                chk("flags", {range_err, lock_timeout_err, proto_err}, {m_rng, m_tmo, m_proto});
                chk("clken", mem_clken, 1);
                chk("mem_cs", mem_chipselect, g && inr);
                chk("mem_wr", mem_write, g && inr && s_wr);
                if (g && inr) begin
                    chk("mem_addr", mem_address, s_addr);
                    if (s_wr) begin
                        chk("mem_be", mem_byteenable, s_be);
                        chk("mem_wd", mem_writedata, s_wd);
                    end
                end

                pend      = g && s_rd && !s_wr;
                pend_b    = gb;
                pend_data = inr ? ref_mem[s_addr] : 32'h0;
                if (g && s_wr && inr)
                    for (int b = 0; b < 4; b++)
                        if (s_be[b]) ref_mem[s_addr][8*b +: 8] = s_wd[8*b +: 8];
                if (g && !inr)        m_rng = 1;
                if (g && s_rd && s_wr) m_proto = 1;

                if (owner == 0) begin
                    if (g && s_lk) owner = ga ? 1 : 2;
                    idle = 0;
                end else begin
                    own_req = (owner == 1) ? ra : rb;
                    own_g   = (owner == 1) ? ga : gb;
                    if (own_g) begin
                        idle = 0;
                        if (!s_lk) owner = 0;
                    end else if (!own_req) begin
                        idle++;
                        if (idle == LT) begin owner = 0; idle = 0; m_tmo = 1; end
                    end
                end
                if (g) last_b = gb;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic rd, input logic wr, input logic lk,
                         input logic [AW-1:0] ad, input logic [31:0] wd, input logic [3:0] be);
        a_read = rd; a_write = wr; a_lock = lk; a_address = ad; a_writedata = wd; a_byteenable = be;
    endtask

    task automatic set_b(input logic rd, input logic wr, input logic lk,
                         input logic [AW-1:0] ad, input logic [31:0] wd, input logic [3:0] be);
        b_read = rd; b_write = wr; b_lock = lk; b_address = ad; b_writedata = wd; b_byteenable = be;
    endtask

    task automatic idle_all();
        set_a(0, 0, 0, '0, '0, '0);
        set_b(0, 0, 0, '0, '0, '0);
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 9) == 0) return AW'($urandom_range(NW - 10, (1 << AW) - 1));
        return AW'($urandom_range(0, 63));
    endfunction

    task automatic rnd_master(input int pct, output logic rd, output logic wr, output logic lk,
                              output logic [AW-1:0] ad, output logic [31:0] wd, output logic [3:0] be);
        int k;
        rd = 0; wr = 0;
        if ($urandom_range(0, 99) < pct) begin
            k  = $urandom_range(0, 19);
            rd = (k < 10) || (k == 19);
            wr = (k >= 10);
        end
        lk = ($urandom_range(0, 5) == 0);
        ad = rnd_addr();
        wd = $urandom;
        be = 4'($urandom_range(0, 15));
    endtask

    initial begin : stimulus
        int pa, pb;
        reset = 1'b1;
        idle_all();
        set_a(1, 0, 0, 13'h0, '0, '0);
        step(); step();
        @(negedge clk);
        chk("d_rst_a_wait", a_waitrequest, 1);
        chk("d_rst_cs", mem_chipselect, 0);
        step();
        reset = 1'b0;
        idle_all();

        // Single read of a preloaded word.
        step();
        set_a(1, 0, 0, 13'h10, '0, '0);
        @(negedge clk);
        chk("s1_a_wait", a_waitrequest, 0);
        chk("s1_cs", mem_chipselect, 1);
        step();
        idle_all();
        @(negedge clk);
        chk("s1_a_rdv", a_readdatavalid, 1);
        chk("s1_data", a_readdata, 32'hC0DE0010);
        chk("s1_b_rdv", b_readdatavalid, 0);

        // Fresh reset, then both masters read continuously: A,B,A,B.
        step(); reset = 1'b1;
        step(); step(); reset = 1'b0;
        set_a(1, 0, 0, 13'h1, '0, '0);
        set_b(1, 0, 0, 13'h2, '0, '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("s2_a_wait", a_waitrequest, (k % 2));
            chk("s2_b_wait", b_waitrequest, 1 - (k % 2));
            if (k > 0) begin
                chk("s2_a_rdv", a_readdatavalid, (k % 2));
                chk("s2_b_rdv", b_readdatavalid, 1 - (k % 2));
                chk("s2_data", a_readdata, (k % 2) ? 32'hC0DE0001 : 32'hC0DE0002);
            end
            step();
        end
        idle_all();
        @(negedge clk);
        chk("s2_b_rdv_last", b_readdatavalid, 1);
        chk("s2_data_last", b_readdata, 32'hC0DE0002);

        // Locked partial write, locked read-back with release, then B.
        step();
        set_a(0, 1, 1, 13'h20, 32'hDEADBEEF, 4'h3);
        set_b(1, 0, 0, 13'h5, '0, '0);
        @(negedge clk);
        chk("s3_a_wait0", a_waitrequest, 0);
        chk("s3_b_wait0", b_waitrequest, 1);
        chk("s3_mem_wr", mem_write, 1);
        step();
        set_a(1, 0, 0, 13'h20, '0, '0);
        @(negedge clk);
        chk("s3_a_wait1", a_waitrequest, 0);
        chk("s3_b_wait1", b_waitrequest, 1);
        step();
        set_a(0, 0, 0, '0, '0, '0);
        @(negedge clk);
        chk("s3_a_rdv", a_readdatavalid, 1);
        chk("s3_data", a_readdata, 32'hC0DEBEEF);
        chk("s3_b_wait2", b_waitrequest, 0);
        step();
        set_b(0, 0, 0, '0, '0, '0);
        @(negedge clk);
        chk("s3_b_rdv", b_readdatavalid, 1);
        chk("s3_b_data", b_readdata, 32'hC0DE0005);

        // Lock then go idle: B waits 16 cycles, granted in the 17th.
        step();
        set_a(0, 1, 1, 13'h30, 32'h12345678, 4'hF);
        set_b(1, 0, 0, 13'h6, '0, '0);
        @(negedge clk);
        chk("s4_a_wait", a_waitrequest, 0);
        chk("s4_b_wait0", b_waitrequest, 1);
        step();
        set_a(0, 0, 0, '0, '0, '0);
        for (int i = 1; i <= LT; i++) begin
            @(negedge clk);
            chk("s4_b_held", b_waitrequest, 1);
            if (i == LT) chk("s4_tmo_before", lock_timeout_err, 0);
            step();
        end
        @(negedge clk);
        chk("s4_b_grant", b_waitrequest, 0);
        chk("s4_tmo_err", lock_timeout_err, 1);

        // Out-of-range write and read from B.
        step();
        set_b(0, 1, 0, 13'd5120, 32'h1, 4'hF);
        @(negedge clk);
        chk("s5_b_wait", b_waitrequest, 0);
        chk("s5_cs_w", mem_chipselect, 0);
        chk("s5_mem_wr", mem_write, 0);
        step();
        set_b(1, 0, 0, 13'd5120, '0, '0);
        @(negedge clk);
        chk("s5_cs_r", mem_chipselect, 0);
        step();
        set_b(1, 0, 0, 13'd0, '0, '0);
        @(negedge clk);
        chk("s5_rdv", b_readdatavalid, 1);
        chk("s5_zero", b_readdata, 0);
        chk("s5_range_err", range_err, 1);
        step();
        idle_all();
        @(negedge clk);
        chk("s5_word0", b_readdata, 32'hC0DE0000);

        // Combined read+write behaves as a write.
        step();
        set_a(1, 1, 0, 13'h40, 32'hA5A5A5A5, 4'hF);
        @(negedge clk);
        chk("s6_mem_wr", mem_write, 1);
        step();
        idle_all();
        @(negedge clk);
        chk("s6_no_rdv", a_readdatavalid, 0);
        chk("s6_proto", proto_err, 1);

        // Reset between grant and data beat.
        step();
        set_a(1, 0, 0, 13'h10, '0, '0);
        @(negedge clk);
        chk("s7_a_wait", a_waitrequest, 0);
        step();
        reset = 1'b1;
        idle_all();
        @(negedge clk);
        chk("s7_no_rdv", a_readdatavalid, 0);
        chk("s7_flags", {range_err, lock_timeout_err, proto_err}, 0);
        step(); step();
        reset = 1'b0;
        set_a(1, 0, 0, 13'h1, '0, '0);
        set_b(1, 0, 0, 13'h2, '0, '0);
        @(negedge clk);
        chk("s7_tie_a", a_waitrequest, 0);
        chk("s7_tie_b", b_waitrequest, 1);

        // Randomized traffic with activity phases and occasional resets.
        pa = 70; pb = 70;
        for (int c = 0; c < 4000; c++) begin
            step();
            if (c % 200 == 0) begin
                pa = ($urandom_range(0, 2) == 0) ? 10 : 70;
                pb = ($urandom_range(0, 2) == 0) ? 10 : 70;
            end
            reset = ($urandom_range(0, 199) == 0);
            rnd_master(pa, a_read, a_write, a_lock, a_address, a_writedata, a_byteenable);
            rnd_master(pb, b_read, b_write, b_lock, b_address, b_writedata, b_byteenable);
        end
        step();
        reset = 1'b0;
        idle_all();
        step(); step();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
